mem_stage: RTL and testbench

//  Consumer end of the EXE->MEM pipeline register. Takes exe_mem_cu_signals and exe_mem_interface,

---
 rtl/stages_definition_pkg.sv | 49 ++++
 rtl/mem_stage_if.sv | 31 +++
 rtl/mem_stage_pix_byte_sequencer.sv | 114 +++++++++++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stages_definition_pkg.sv
// Shared pipeline-stage definitions: memory-stage FSM states, memToReg
// encodings and the EXE->MEM / MEM->WB bus payloads.
package stages_definition_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned RD_W         = 4;
    localparam int unsigned MEM_TO_REG_W = 2;

    localparam logic [MEM_TO_REG_W-1:0] MEM_TO_REG_ALU  = 2'b00;
    localparam logic [MEM_TO_REG_W-1:0] MEM_TO_REG_DMEM = 2'b01;
    localparam logic [MEM_TO_REG_W-1:0] MEM_TO_REG_PIX  = 2'b10;
    localparam logic [MEM_TO_REG_W-1:0] MEM_TO_REG_TRIG = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        PIX_WR,
        PIX_RD
    } mem_stage_state_e;

    typedef struct packed {
        logic                    regWrite;
        logic                    pcSrc;
        logic [MEM_TO_REG_W-1:0] memToReg;
        logic                    memWrite;
        logic                    memPixWrite;
    } exe_mem_cu_signals_t;

    typedef struct packed {
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] trigResult;
        logic [DATA_W-1:0] R0;
        logic [DATA_W-1:0] R1;
    } exe_mem_interface_t;

    typedef struct packed {
        logic                    regWrite;
        logic                    pcSrc;
        logic [MEM_TO_REG_W-1:0] memToReg;
    } mem_wb_cu_signals_t;

    typedef struct packed {
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] trigResult;
        logic [DATA_W-1:0] dataMemRead;
        logic [DATA_W-1:0] pixMemRead;
    } mem_wb_interface_t;

endpackage

// File: rtl/mem_stage_if.sv
// Memory-side bus of the MEM stage: one word-wide data memory and one
// byte-wide pixel memory, both with a synchronous (next-cycle) read.
//   master : the MEM stage (drives address/write data/strobe, takes read data)
//   slave  : the memories
interface mem_stage_if #(
    parameter int unsigned DADDR_W = 10,
    parameter int unsigned PADDR_W = 16
);
    logic [DADDR_W-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic               dmem_we;
    logic [31:0]        dmem_rdata;
    logic [PADDR_W-1:0] pmem_addr;
    logic [7:0]         pmem_wdata;
    logic               pmem_we;
    logic [7:0]         pmem_rdata;

    modport master (
        output dmem_addr, dmem_wdata, dmem_we,
        input  dmem_rdata,
        output pmem_addr, pmem_wdata, pmem_we,
        input  pmem_rdata
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_we,
        output dmem_rdata,
        input  pmem_addr, pmem_wdata, pmem_we,
        output pmem_rdata
    );
endinterface

// File: rtl/mem_stage_pix_byte_sequencer.sv
// Pixel byte sequencer: splits one 32-bit pixel access into four byte beats.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           accept a pixel op (only honoured in IDLE)
//   start_write     1 = write sequence, 0 = read sequence
//   base, wword     byte base address and write word, latched on start
//   pmem_rdata      pixel-memory read byte (valid the cycle after the address)
//   busy_c          sequencer not IDLE
//   done_c          last cycle of the sequence
//   rd_word_c       assembled read word (valid with done_c on a read)
//   pmem_*_c        pixel-memory address / write byte / write strobe
module pix_byte_sequencer
    import stages_definition_pkg::*;
#(
    parameter int unsigned PADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               start_write,
    input  logic [PADDR_W-1:0] base,
    input  logic [31:0]        wword,
    input  logic [7:0]         pmem_rdata,
    output logic               busy_c,
    output logic               done_c,
    output logic [31:0]        rd_word_c,
    output logic [PADDR_W-1:0] pmem_addr_c,
    output logic [7:0]         pmem_wdata_c,
    output logic               pmem_we_c
);

    mem_stage_state_e   state, state_nxt;
    logic [1:0]         beat, beat_nxt;
    logic               drain, drain_nxt;
    logic [PADDR_W-1:0] base_q;
    logic [31:0]        wword_q;
    logic [23:0]        asm_q;
    logic               capture_c;
    logic [1:0]         cap_idx_c;

    // State register plus latched operands and read-assembly bytes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat    <= 2'd0;
            drain   <= 1'b0;
            base_q  <= '0;
            wword_q <= '0;
            asm_q   <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            drain <= drain_nxt;
            if (start && (state == IDLE)) begin
                base_q  <= base;
                wword_q <= wword;
                asm_q   <= '0;
            end
            if (capture_c) begin
                case (cap_idx_c)
                    2'd0:    asm_q[7:0]   <= pmem_rdata;
                    2'd1:    asm_q[15:8]  <= pmem_rdata;
                    2'd2:    asm_q[23:16] <= pmem_rdata;
                    default: ;
                endcase
            end
        end
    end

    // Next state; reads need one extra drain cycle for the last byte to return
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        drain_nxt = drain;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = start_write ? PIX_WR : PIX_RD;
                    beat_nxt  = 2'd0;
                    drain_nxt = 1'b0;
                end
            end
            PIX_WR: begin
                beat_nxt = beat + 2'd1;
                if (beat == 2'd3) state_nxt = IDLE;
            end
            PIX_RD: begin
                if (drain) begin
                    state_nxt = IDLE;
                    drain_nxt = 1'b0;
                end else begin
                    beat_nxt = beat + 2'd1;
                    if (beat == 2'd3) drain_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; the byte returned this cycle belongs to the previous beat,
    // so beat-1 (wrapping to 3 in the drain cycle) is the capture lane
    always_comb begin
        busy_c       = (state != IDLE);
        pmem_we_c    = (state == PIX_WR);
        pmem_addr_c  = base_q + PADDR_W'(beat);
        pmem_wdata_c = wword_q[{beat, 3'b000} +: 8];
        capture_c    = (state == PIX_RD) && ((beat != 2'd0) || drain);
        cap_idx_c    = beat - 2'd1;
        done_c       = ((state == PIX_WR) && (beat == 2'd3)) ||
                       ((state == PIX_RD) && drain);
        rd_word_c    = {pmem_rdata, asm_q};
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: consumes the EXE->MEM register, drives data memory
// (one word per access) and pixel memory (four byte beats per word), and
// produces the registered MEM->WB bundle. Holds upstream while a pixel
// access sequences.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_cu/in_data/in_rd  EXE->MEM instruction
//   stall                   upstream must hold in_*; in_valid ignored
//   mem                     data/pixel memory bus (mem_stage_if.master)
//   out_valid/out_cu/out_data/out_rd  MEM->WB bundle
//   stall_cycles            stalled-cycle counter (only with MEM_STALL_COUNT_EN)
module mem_stage
    import stages_definition_pkg::*;
#(
    parameter int unsigned DADDR_W = 10,
    parameter int unsigned PADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  exe_mem_cu_signals_t in_cu,
    input  exe_mem_interface_t  in_data,
    input  logic [RD_W-1:0]     in_rd,
    output logic                stall,
    mem_stage_if.master         mem,
    output logic                out_valid,
    output mem_wb_cu_signals_t  out_cu,
    output mem_wb_interface_t   out_data,
    output logic [RD_W-1:0]     out_rd
`ifdef MEM_STALL_COUNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    logic               accept_c;
    logic               pix_op_c;
    logic               seq_busy_c;
    logic               seq_done_c;
    logic [31:0]        seq_rd_word_c;
    mem_wb_cu_signals_t lat_cu;
    logic [31:0]        lat_alu;
    logic [31:0]        lat_trig;
    logic [RD_W-1:0]    lat_rd;
    logic               lat_write;
    logic [31:0]        out_alu_q;
    logic [31:0]        out_trig_q;
    logic [31:0]        out_pix_q;
    logic               out_dmem_sel_q;

    // Accept / data-memory side; the data write happens only in the accept cycle
    always_comb begin
        stall          = seq_busy_c;
        accept_c       = in_valid && !seq_busy_c;
        pix_op_c       = in_cu.memPixWrite || (in_cu.memToReg == MEM_TO_REG_PIX);
        mem.dmem_addr  = in_data.aluResult[DADDR_W+1:2];
        mem.dmem_wdata = in_data.R0;
        mem.dmem_we    = accept_c && in_cu.memWrite;
    end

    pix_byte_sequencer #(.PADDR_W(PADDR_W)) u_pix_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (accept_c && pix_op_c),
        .start_write  (in_cu.memPixWrite),
        .base         (in_data.aluResult[PADDR_W-1:0]),
        .wword        (in_data.R1),
        .pmem_rdata   (mem.pmem_rdata),
        .busy_c       (seq_busy_c),
        .done_c       (seq_done_c),
        .rd_word_c    (seq_rd_word_c),
        .pmem_addr_c  (mem.pmem_addr),
        .pmem_wdata_c (mem.pmem_wdata),
        .pmem_we_c    (mem.pmem_we)
    );

    // Pass-through fields of a pixel op, held until its sequence completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_cu    <= '0;
            lat_alu   <= '0;
            lat_trig  <= '0;
            lat_rd    <= '0;
            lat_write <= 1'b0;
        end else if (accept_c && pix_op_c) begin
            lat_cu    <= '{in_cu.regWrite, in_cu.pcSrc, in_cu.memToReg};
            lat_alu   <= in_data.aluResult;
            lat_trig  <= in_data.trigResult;
            lat_rd    <= in_rd;
            lat_write <= in_cu.memPixWrite;
        end
    end

    // MEM->WB register: plain ops complete next cycle, pixel ops on done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_cu         <= '0;
            out_alu_q      <= '0;
            out_trig_q     <= '0;
            out_pix_q      <= '0;
            out_rd         <= '0;
            out_dmem_sel_q <= 1'b0;
        end else if (accept_c && !pix_op_c) begin
            out_valid      <= 1'b1;
            out_cu         <= '{in_cu.regWrite, in_cu.pcSrc, in_cu.memToReg};
            out_alu_q      <= in_data.aluResult;
            out_trig_q     <= in_data.trigResult;
            out_pix_q      <= '0;
            out_rd         <= in_rd;
            out_dmem_sel_q <= (in_cu.memToReg == MEM_TO_REG_DMEM);
        end else if (seq_done_c) begin
            out_valid      <= 1'b1;
            out_cu         <= lat_cu;
            out_alu_q      <= lat_alu;
            out_trig_q     <= lat_trig;
            out_pix_q      <= lat_write ? 32'd0 : seq_rd_word_c;
            out_rd         <= lat_rd;
            out_dmem_sel_q <= 1'b0;
        end else begin
            out_valid      <= 1'b0;
            out_dmem_sel_q <= 1'b0;
        end
    end

    // Data-memory read word arrives the cycle after the address, alongside out_valid
    always_comb begin
        out_data.aluResult   = out_alu_q;
        out_data.trigResult  = out_trig_q;
        out_data.dataMemRead = out_dmem_sel_q ? mem.dmem_rdata : 32'd0;
        out_data.pixMemRead  = out_pix_q;
    end

`ifdef MEM_STALL_COUNT_EN
    // Free-running count of stalled cycles
    always_ff @(posedge clk) begin
        if (!rst_n)          stall_cycles <= 32'd0;
        else if (seq_busy_c) stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with behavioural data and pixel memories.
module tb_mem_stage;
    import stages_definition_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    exe_mem_cu_signals_t in_cu;
    exe_mem_interface_t  in_data;
    logic [RD_W-1:0]     in_rd;
    logic                stall;
    logic                out_valid;
    mem_wb_cu_signals_t  out_cu;
    mem_wb_interface_t   out_data;
    logic [RD_W-1:0]     out_rd;
`ifdef MEM_STALL_COUNT_EN
    logic [31:0]         stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] dmem [1024];
    logic [7:0]  pmem [65536];

    mem_stage_if #(.DADDR_W(10), .PADDR_W(16)) mif ();

    mem_stage #(.DADDR_W(10), .PADDR_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_cu        (in_cu),
        .in_data      (in_data),
        .in_rd        (in_rd),
        .stall        (stall),
        .mem          (mif),
        .out_valid    (out_valid),
        .out_cu       (out_cu),
        .out_data     (out_data),
        .out_rd       (out_rd)
`ifdef MEM_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories
    always @(posedge clk) begin
        if (mif.dmem_we) dmem[mif.dmem_addr] <= mif.dmem_wdata;
        mif.dmem_rdata <= dmem[mif.dmem_addr];
        if (mif.pmem_we) pmem[mif.pmem_addr] <= mif.pmem_wdata;
        mif.pmem_rdata <= pmem[mif.pmem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pixel op; inputs held through the stall, dropped on completion
    task automatic run_pix(input logic [15:0] base, input logic [31:0] r1, input logic [31:0] r0,
                           input logic wr, input logic rd_sel, input logic dwr,
                           input logic [31:0] exp_pix);
        int          n_stall;
        logic [15:0] a;
        logic [31:0] sh;
        n_stall = wr ? 4 : 5;
        step();
        in_valid            = 1'b1;
        in_cu               = '0;
        in_cu.memPixWrite   = wr;
        in_cu.memToReg      = rd_sel ? MEM_TO_REG_PIX : MEM_TO_REG_ALU;
        in_cu.memWrite      = dwr;
        in_cu.regWrite      = 1'b1;
        in_data             = '0;
        in_data.aluResult   = {16'h0000, base};
        in_data.trigResult  = 32'h7777_0001;
        in_data.R0          = r0;
        in_data.R1          = r1;
        in_rd               = 4'd7;
        @(negedge clk);
        check("pix_n_stall", 32'(stall), 32'd0);
        check("pix_n_dmem_we", 32'(mif.dmem_we), 32'(dwr));
        check("pix_n_pmem_we", 32'(mif.pmem_we), 32'd0);
        for (int k = 1; k <= n_stall; k++) begin
            step();
            @(negedge clk);
            check($sformatf("pix_stall%0d", k), 32'(stall), 32'd1);
            check($sformatf("pix_ovalid%0d", k), 32'(out_valid), 32'd0);
            check($sformatf("pix_dwe%0d", k), 32'(mif.dmem_we), 32'd0);
            if (k <= 4) begin
                a = base + 16'(k - 1);
                check($sformatf("pix_addr%0d", k), 32'(mif.pmem_addr), {16'h0, a});
                check($sformatf("pix_we%0d", k), 32'(mif.pmem_we), 32'(wr));
                if (wr) begin
                    sh = r1 >> (8 * (k - 1));
                    check($sformatf("pix_wdata%0d", k), 32'(mif.pmem_wdata), {24'h0, sh[7:0]});
                end
            end
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("pix_done_stall", 32'(stall), 32'd0);
        check("pix_done_valid", 32'(out_valid), 32'd1);
        check("pix_done_read", out_data.pixMemRead, exp_pix);
        check("pix_done_m2r", 32'(out_cu.memToReg), rd_sel ? 32'd2 : 32'd0);
        check("pix_done_alu", out_data.aluResult, {16'h0, base});
        check("pix_done_trig", out_data.trigResult, 32'h7777_0001);
        check("pix_done_rd", 32'(out_rd), 32'd7);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)  dmem[i] = 32'h0;
        for (int i = 0; i < 65536; i++) pmem[i] = 8'hEE;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_cu    = '0;
        in_data  = '0;
        in_rd    = '0;
        step();
        step();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_dmem_we", 32'(mif.dmem_we), 32'd0);
        check("rst_pmem_we", 32'(mif.pmem_we), 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_alu", out_data.aluResult, 32'd0);
        check("rst_out_dmem", out_data.dataMemRead, 32'd0);
        step();
        rst_n = 1'b1;

        // ALU op
        step();
        in_valid          = 1'b1;
        in_cu             = '0;
        in_cu.regWrite    = 1'b1;
        in_cu.pcSrc       = 1'b1;
        in_data           = '0;
        in_data.aluResult = 32'h0000_1234;
        in_data.trigResult = 32'hABCD_0000;
        in_rd             = 4'd5;
        @(negedge clk);
        check("alu_stall_n", 32'(stall), 32'd0);
        check("alu_dmem_we", 32'(mif.dmem_we), 32'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("alu_valid", 32'(out_valid), 32'd1);
        check("alu_result", out_data.aluResult, 32'h0000_1234);
        check("alu_trig", out_data.trigResult, 32'hABCD_0000);
        check("alu_rd", 32'(out_rd), 32'd5);
        check("alu_regwrite", 32'(out_cu.regWrite), 32'd1);
        check("alu_pcsrc", 32'(out_cu.pcSrc), 32'd1);
        check("alu_stall_n1", 32'(stall), 32'd0);
        step();
        @(negedge clk);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_pmem_we", 32'(mif.pmem_we), 32'd0);

        // Data-memory store then load of the same word
        step();
        in_valid          = 1'b1;
        in_cu             = '0;
        in_cu.memWrite    = 1'b1;
        in_data           = '0;
        in_data.aluResult = 32'h0000_0010;
        in_data.R0        = 32'hCAFE_BABE;
        in_rd             = 4'd0;
        @(negedge clk);
        check("st_dmem_we", 32'(mif.dmem_we), 32'd1);
        check("st_dmem_addr", 32'(mif.dmem_addr), 32'd4);
        check("st_dmem_wdata", mif.dmem_wdata, 32'hCAFE_BABE);
        step();
        in_cu             = '0;
        in_cu.regWrite    = 1'b1;
        in_cu.memToReg    = MEM_TO_REG_DMEM;
        in_rd             = 4'd3;
        @(negedge clk);
        check("ld_dmem_we", 32'(mif.dmem_we), 32'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("ld_valid", 32'(out_valid), 32'd1);
        check("ld_data", out_data.dataMemRead, 32'hCAFE_BABE);
        check("ld_rd", 32'(out_rd), 32'd3);

        // Data write + pixel write + memToReg=PIX: write only, no read data
        run_pix(16'h0020, 32'h0A0B_0C0D, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1, 32'h0);
        check("combo_dmem", dmem[8], 32'h5555_AAAA);
        check("combo_pmem3", {24'h0, pmem[16'h0023]}, 32'h0000_000A);

        // Reset in the middle of a pixel write
        step();
        in_valid          = 1'b1;
        in_cu             = '0;
        in_cu.memPixWrite = 1'b1;
        in_data           = '0;
        in_data.aluResult = 32'h0000_0100;
        in_data.R1        = 32'hDDCC_BBAA;
        step();
        @(negedge clk);
        check("rstmid_addr0", 32'(mif.pmem_addr), 32'h0000_0100);
        step();
        @(negedge clk);
        check("rstmid_we1", 32'(mif.pmem_we), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rstmid_stall", 32'(stall), 32'd0);
        check("rstmid_pmem_we", 32'(mif.pmem_we), 32'd0);
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_b0", {24'h0, pmem[16'h0100]}, 32'h0000_00AA);
        check("rstmid_b1", {24'h0, pmem[16'h0101]}, 32'h0000_00BB);
        check("rstmid_b2", {24'h0, pmem[16'h0102]}, 32'h0000_00EE);
        check("rstmid_b3", {24'h0, pmem[16'h0103]}, 32'h0000_00EE);

        // Pixel write across the address wrap, then read it back
        run_pix(16'hFFFE, 32'h4433_2211, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_b0", {24'h0, pmem[16'hFFFE]}, 32'h0000_0011);
        check("wrap_b1", {24'h0, pmem[16'hFFFF]}, 32'h0000_0022);
        check("wrap_b2", {24'h0, pmem[16'h0000]}, 32'h0000_0033);
        check("wrap_b3", {24'h0, pmem[16'h0001]}, 32'h0000_0044);
        run_pix(16'hFFFE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4433_2211);
`ifdef MEM_STALL_COUNT_EN
        check("stall_cycles", stall_cycles, 32'd9);
`endif
        step();
        @(negedge clk);
        check("after_valid", 32'(out_valid), 32'd0);
        check("after_stall", 32'(stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
